// File: rtl/comp2.sv
// Magnitude comparator: per-bit compare cells feed an MSB-first priority chain,
// producing mutually exclusive gt/eq/lt flags, optionally registered.

module comp2_cell #(
  parameter bit SIGN_BIT = 1'b0
) (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq
);
  // In a two's-complement MSB a set bit means negative, so the sense flips.
  assign gt = SIGN_BIT ? (~a & b) : (a & ~b);
  assign eq = ~(a ^ b);
endmodule

module comp2 #(
  parameter int WIDTH      = 3,
  parameter bit SIGNED     = 1'b0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  output logic             z
);
  logic [WIDTH-1:0] bit_gt, bit_eq;
  logic [WIDTH:0]   gt_c, eq_c;
  logic             gt, eq, lt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    comp2_cell #(.SIGN_BIT(SIGNED && (i == WIDTH-1))) u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .gt (bit_gt[i]),
      .eq (bit_eq[i])
    );
  end

  // gt_c[i]/eq_c[i] summarise bits WIDTH-1 down to i; the first differing bit decides.
  assign gt_c[WIDTH] = 1'b0;
  assign eq_c[WIDTH] = 1'b1;
  for (genvar i = WIDTH-1; i >= 0; i--) begin : g_chain
    assign gt_c[i] = gt_c[i+1] | (eq_c[i+1] & bit_gt[i]);
    assign eq_c[i] = eq_c[i+1] & bit_eq[i];
  end

  assign gt = gt_c[0];
  assign eq = eq_c[0];
  assign lt = ~gt_c[0] & ~eq_c[0];

  if (REGISTERED) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        x <= 1'b0;
        y <= 1'b0;
        z <= 1'b0;
      end else begin
        x <= gt;
        y <= eq;
        z <= lt;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign x = gt;
    assign y = eq;
    assign z = lt;
  end
endmodule

// File: tb/tb_comp2.sv
// Scoreboard bench for comp2: unsigned/registered, signed/registered and
// combinational instances share one stimulus stream.

module tb_comp2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a = 3'd0, b = 3'd0;
  logic       xu, yu, zu, xs, ys, zs, xc, yc, zc;
  int         checks = 0, errors = 0;
  int         cyc = 0;

  typedef struct {
    logic [2:0] u;
    logic [2:0] s;
    int         cyc;
    string      nm;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp2 #(.WIDTH(3), .SIGNED(1'b0), .REGISTERED(1'b1)) dut_u (
    .clk(clk), .rst(rst), .a(a), .b(b), .x(xu), .y(yu), .z(zu));
  comp2 #(.WIDTH(3), .SIGNED(1'b1), .REGISTERED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .x(xs), .y(ys), .z(zs));
  comp2 #(.WIDTH(3), .SIGNED(1'b0), .REGISTERED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .a(a), .b(b), .x(xc), .y(yc), .z(zc));

  // {x,y,z} encoding: 100 = a>b, 010 = equal, 001 = a<b
  function automatic logic [2:0] ucmp(input logic [2:0] av, input logic [2:0] bv);
    if (av > bv)       return 3'b100;
    else if (av == bv) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  // Issue one vector; the registered expectation becomes visible one edge later.
  task automatic drive(input logic [2:0] av, input logic [2:0] bv, input logic r,
                       input logic [2:0] eu, input logic [2:0] es, input string nm);
    @(posedge clk);
    #1;
    a = av; b = bv; rst = r;
    q.push_back('{u: eu, s: es, cyc: cyc, nm: nm});
    #1;
    check({nm, "_comb"}, {xc, yc, zc}, ucmp(av, bv));
  endtask

  // Monitor: pops entries issued before the current edge and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check({e.nm, "_u"}, {xu, yu, zu}, e.u);
        check({e.nm, "_s"}, {xs, ys, zs}, e.s);
        if (e.u != 3'b000) check({e.nm, "_onehot"}, 3'($onehot({xu, yu, zu})), 3'd1);
      end
    end
  end

  initial begin
    int wait_cyc;
    // reset holds flags low whatever the operands
    drive(3'd3, 3'd0, 1'b1, 3'b000, 3'b000, "reset");
    drive(3'd3, 3'd0, 1'b0, 3'b100, 3'b100, "post_reset");
    // small-range sweep: signed and unsigned agree for 0..3
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        drive(3'(i), 3'(j), 1'b0, ucmp(3'(i), 3'(j)), ucmp(3'(i), 3'(j)),
              $sformatf("sweep_%0d_%0d", i, j));
    // full-range corners; 7 is -1 when signed
    drive(3'd7, 3'd0, 1'b0, 3'b100, 3'b001, "max_0");
    drive(3'd0, 3'd7, 1'b0, 3'b001, 3'b100, "0_max");
    drive(3'd7, 3'd7, 1'b0, 3'b010, 3'b010, "max_max");
    // signed: -4 vs +3, -1 vs -2, 0 vs 0
    drive(3'b100, 3'b011, 1'b0, 3'b100, 3'b001, "neg4_pos3");
    drive(3'b111, 3'b110, 1'b0, 3'b100, 3'b100, "neg1_neg2");
    drive(3'b000, 3'b000, 1'b0, 3'b010, 3'b010, "zero_zero");
    // back-to-back toggling with a one-cycle reset in the middle
    drive(3'd0, 3'd1, 1'b0, 3'b001, 3'b001, "alt0");
    drive(3'd1, 3'd0, 1'b0, 3'b100, 3'b100, "alt1");
    drive(3'd0, 3'd1, 1'b0, 3'b001, 3'b001, "alt2");
    drive(3'd1, 3'd0, 1'b1, 3'b000, 3'b000, "alt_rst");
    drive(3'd0, 3'd1, 1'b0, 3'b001, 3'b001, "alt3");
    drive(3'd1, 3'd0, 1'b0, 3'b100, 3'b100, "alt4");

    // drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    // combinational instance responds mid-cycle with no clock edge
    a = 3'd2; b = 3'd1;
    #1;
    check("comb_no_edge", {xc, yc, zc}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
